// File: rtl/adc_segment_encoder.sv
// ADC sample to three seven-segment patterns using a sequential double-dabble
// engine, plus the free-running refresh prescaler that sweeps the digit select.
module adc_segment_encoder #(
  parameter int unsigned REFRESH_DIV   = 50000,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic [7:0] Sample,
  input  logic       Sample_valid,
  output logic       Busy,
  output logic       Update_done,
  output logic [7:0] Ones,
  output logic [7:0] Tens,
  output logic [7:0] Hundreds,
  output logic [1:0] Sel
);

  localparam int unsigned PW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned SAMPLE_W = 8;
  localparam int unsigned BCD_W    = 12;
  localparam int unsigned CNT_W    = 4;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] LOAD  = 2'd2;

  localparam logic [7:0] SEG_ZERO  = 8'h3F;
  localparam logic [7:0] SEG_LEAD0 = (BLANK_LEADING == 1'b1) ? 8'h00 : 8'h3F;

  logic [1:0]          state, next_state;
  logic                capture, do_shift, do_load;
  logic [SAMPLE_W-1:0] shreg;
  logic [BCD_W-1:0]    bcd;
  logic [CNT_W-1:0]    cnt;
  logic [BCD_W-1:0]    bcd_adj;
  logic [BCD_W+SAMPLE_W-1:0] dd_shifted;
  logic [7:0]          ones_pat, tens_pat, hund_pat;
  logic [PW-1:0]       presc;

  function automatic logic [3:0] adj3(input logic [3:0] n);
    return (n >= 4'd5) ? 4'(n + 4'd3) : n;
  endfunction

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 8'h3F;
      4'd1:    return 8'h06;
      4'd2:    return 8'h5B;
      4'd3:    return 8'h4F;
      4'd4:    return 8'h66;
      4'd5:    return 8'h6D;
      4'd6:    return 8'h7D;
      4'd7:    return 8'h07;
      4'd8:    return 8'h7F;
      4'd9:    return 8'h6F;
      default: return 8'h00;
    endcase
  endfunction

  // State register
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state and datapath control
  always_comb begin
    next_state = state;
    capture    = 1'b0;
    do_shift   = 1'b0;
    do_load    = 1'b0;
    case (state)
      IDLE: begin
        if (Sample_valid) begin
          capture    = 1'b1;
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        do_shift = 1'b1;
        if (cnt == CNT_W'(1)) next_state = LOAD;
      end
      LOAD: begin
        do_load    = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // One double-dabble step: add-3 correction then shift {bcd,shreg} left
  always_comb begin
    bcd_adj    = {adj3(bcd[11:8]), adj3(bcd[7:4]), adj3(bcd[3:0])};
    dd_shifted = {bcd_adj, shreg} << 1;
  end

  // Pattern encode with optional leading-zero blanking
  always_comb begin
    ones_pat = seg7(bcd[3:0]);
    tens_pat = seg7(bcd[7:4]);
    hund_pat = seg7(bcd[11:8]);
    if (BLANK_LEADING == 1'b1) begin
      if (bcd[11:8] == 4'd0) hund_pat = 8'h00;
      if (bcd[11:4] == 8'd0) tens_pat = 8'h00;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      shreg       <= '0;
      bcd         <= '0;
      cnt         <= '0;
      Busy        <= 1'b0;
      Update_done <= 1'b0;
      Ones        <= SEG_ZERO;
      Tens        <= SEG_LEAD0;
      Hundreds    <= SEG_LEAD0;
    end else begin
      Update_done <= do_load;
      if (capture) begin
        shreg <= Sample;
        bcd   <= '0;
        cnt   <= CNT_W'(SAMPLE_W);
        Busy  <= 1'b1;
      end else if (do_shift) begin
        bcd   <= dd_shifted[BCD_W+SAMPLE_W-1:SAMPLE_W];
        shreg <= dd_shifted[SAMPLE_W-1:0];
        cnt   <= cnt - CNT_W'(1);
      end else if (do_load) begin
        Ones     <= ones_pat;
        Tens     <= tens_pat;
        Hundreds <= hund_pat;
        Busy     <= 1'b0;
      end
    end
  end

  // Refresh prescaler, independent of the conversion FSM
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      presc <= '0;
      Sel   <= 2'b00;
    end else if (presc == PW'(REFRESH_DIV - 1)) begin
      presc <= '0;
      Sel   <= Sel + 2'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

endmodule

// File: tb/tb_adc_segment_encoder.sv
// Scoreboard bench: two instances (blanking on/off) share stimulus; expected
// patterns are queued per accepted strobe and checked on each Update_done.
module tb_adc_segment_encoder;

  typedef struct {
    logic [7:0] h;
    logic [7:0] t;
    logic [7:0] o;
  } exp_t;

  logic       Clock, Reset_n, Sample_valid;
  logic [7:0] Sample;
  logic       busy0, done0, busy1, done1;
  logic [7:0] ones0, tens0, hund0, ones1, tens1, hund1;
  logic [1:0] sel0, sel1;

  int tests = 0;
  int fails = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t m0, m1;

  adc_segment_encoder #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Sample(Sample), .Sample_valid(Sample_valid),
    .Busy(busy0), .Update_done(done0), .Ones(ones0), .Tens(tens0),
    .Hundreds(hund0), .Sel(sel0));

  adc_segment_encoder #(.REFRESH_DIV(4), .BLANK_LEADING(1'b0)) dut_nb (
    .Clock(Clock), .Reset_n(Reset_n), .Sample(Sample), .Sample_valid(Sample_valid),
    .Busy(busy1), .Update_done(done1), .Ones(ones1), .Tens(tens1),
    .Hundreds(hund1), .Sel(sel1));

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] h0, t0, o0, h1, t1, o1);
    exp_t e;
    e.h = h0; e.t = t0; e.o = o0; q0.push_back(e);
    e.h = h1; e.t = t1; e.o = o1; q1.push_back(e);
  endtask

  // Monitors: pop and compare whenever a DUT announces new patterns
  always @(negedge Clock) begin
    if (done0) begin
      if (q0.size() == 0) chk("unexpected_done_blank", 32'd1, 32'd0);
      else begin
        m0 = q0.pop_front();
        chk("hundreds_blank", 32'(hund0), 32'(m0.h));
        chk("tens_blank",     32'(tens0), 32'(m0.t));
        chk("ones_blank",     32'(ones0), 32'(m0.o));
      end
    end
  end

  always @(negedge Clock) begin
    if (done1) begin
      if (q1.size() == 0) chk("unexpected_done_full", 32'd1, 32'd0);
      else begin
        m1 = q1.pop_front();
        chk("hundreds_full", 32'(hund1), 32'(m1.h));
        chk("tens_full",     32'(tens1), 32'(m1.t));
        chk("ones_full",     32'(ones1), 32'(m1.o));
      end
    end
  end

  task automatic strobe(input logic [7:0] v);
    @(posedge Clock); #1;
    Sample = v;
    Sample_valid = 1'b1;
    @(posedge Clock); #1;
    Sample_valid = 1'b0;
  endtask

  // Waits for Update_done, counting negedges with Busy high beforehand
  task automatic wait_done(output int cyc);
    logic got;
    got = 1'b0;
    cyc = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge Clock);
      if (done0) begin
        got = 1'b1;
        break;
      end
      if (busy0) cyc++;
    end
    if (!got) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic finish_conv();
    int c;
    wait_done(c);
    chk("busy_cycles", 32'(c), 32'd9);
    @(negedge Clock);
    chk("done_pulse_width", 32'(done0), 32'd0);
    chk("busy_low_after", 32'(busy0), 32'd0);
  endtask

  initial begin
    int  c;
    logic extra;
    Reset_n = 1'b0;
    Sample = 8'h00;
    Sample_valid = 1'b0;
    #12;
    chk("rst_ones",  32'(ones0), 32'h3F);
    chk("rst_tens",  32'(tens0), 32'h00);
    chk("rst_hund",  32'(hund0), 32'h00);
    chk("rst_sel",   32'(sel0),  32'h0);
    chk("rst_busy",  32'(busy0), 32'h0);
    chk("rst_tens_full", 32'(tens1), 32'h3F);
    chk("rst_hund_full", 32'(hund1), 32'h3F);
    @(negedge Clock);
    Reset_n = 1'b1;

    // Sel sweep runs alongside the first conversion
    fork
      begin
        for (int n = 1; n <= 24; n++) begin
          @(negedge Clock);
          chk("sel_seq", 32'(sel0), 32'((n / 4) % 4));
          chk("sel_seq_full", 32'(sel1), 32'((n / 4) % 4));
        end
      end
      begin
        push(8'h5B, 8'h6D, 8'h6D, 8'h5B, 8'h6D, 8'h6D);
        strobe(8'hFF);
        finish_conv();
      end
    join

    push(8'h00, 8'h00, 8'h07, 8'h3F, 8'h3F, 8'h07);
    strobe(8'd7);
    finish_conv();

    push(8'h06, 8'h3F, 8'h6D, 8'h06, 8'h3F, 8'h6D);
    strobe(8'd105);
    wait_done(c);
    chk("busy_cycles_105", 32'(c), 32'd9);
    // Strobe coincident with Update_done must be accepted
    push(8'h00, 8'h6D, 8'h3F, 8'h3F, 8'h6D, 8'h3F);
    Sample = 8'd50;
    Sample_valid = 1'b1;
    @(posedge Clock); #1;
    Sample_valid = 1'b0;
    finish_conv();

    // Strobe at T3 while busy is dropped
    push(8'h5B, 8'h3F, 8'h3F, 8'h5B, 8'h3F, 8'h3F);
    strobe(8'd200);
    @(posedge Clock);
    @(posedge Clock); #1;
    Sample = 8'd99;
    Sample_valid = 1'b1;
    @(posedge Clock); #1;
    Sample_valid = 1'b0;
    wait_done(c);
    extra = 1'b0;
    repeat (14) begin
      @(negedge Clock);
      if (done0 || busy0) extra = 1'b1;
    end
    chk("dropped_strobe_no_rerun", 32'(extra), 32'd0);

    // Reset in the middle of a conversion
    strobe(8'hC8);
    repeat (4) @(posedge Clock);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("abort_ones", 32'(ones0), 32'h3F);
    chk("abort_tens", 32'(tens0), 32'h00);
    chk("abort_hund", 32'(hund0), 32'h00);
    chk("abort_busy", 32'(busy0), 32'h0);
    chk("abort_done", 32'(done0), 32'h0);
    chk("abort_sel",  32'(sel0),  32'h0);
    chk("abort_hund_full", 32'(hund1), 32'h3F);
    @(negedge Clock);
    Reset_n = 1'b1;
    extra = 1'b0;
    repeat (12) begin
      @(negedge Clock);
      if (done0 || busy0) extra = 1'b1;
    end
    chk("abort_no_done", 32'(extra), 32'd0);

    push(8'h00, 8'h66, 8'h5B, 8'h3F, 8'h66, 8'h5B);
    strobe(8'h2A);
    finish_conv();

    repeat (3) @(negedge Clock);
    chk("queue_empty_blank", 32'(q0.size()), 32'd0);
    chk("queue_empty_full",  32'(q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
